// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl: write/read sequencing for a three-line buffer built from three
// single-line RAMs. Incoming pixels are written round-robin, one line per RAM.
// Once two full lines are stored, each new pixel is written and the same column
// is read from all three RAMs, producing a three-line vertical window.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     a pixel is presented this cycle (accepted beat)
//   frame_start  accepted beat is pixel (0,0) of a new frame (ignored if !in_valid)
//   wr_en        one-hot write strobe to line RAMs 0..2 (combinational)
//   wr_addr      write address, the current column (combinational)
//   rd_en        read all three RAMs at rd_addr (combinational)
//   rd_addr      read address, always equal to wr_addr
//   out_sel      index of the RAM holding the newest line, aligned with out_valid
//   out_valid    three-line column output is valid (registered)
//   eol          one-cycle pulse after the last column of a line (registered)
//   eof          one-cycle pulse after the last pixel of a frame (registered)
module linebuf_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned LENGTH     = 100,
  parameter int unsigned LINES      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  frame_start,
  output logic [2:0]            wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]            out_sel,
  output logic                  out_valid,
  output logic                  eol,
  output logic                  eof
);

  localparam logic [ADDR_WIDTH-1:0] ColLast  = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ColOne   = ADDR_WIDTH'(1);
  localparam logic [7:0]            LineLast = 8'(LINES - 1);

  // StFill0/StFill1: first and second line of a frame are being stored, no
  // window is available yet. StRun: every beat produces a window column.
  typedef enum logic [1:0] {
    StIdle,
    StFill0,
    StFill1,
    StRun
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   col_q, col_d;
  logic [7:0]              line_q, line_d;
  logic [1:0]              wr_sel_q, wr_sel_d;
  logic                    out_valid_q, out_valid_d;
  logic [1:0]              out_sel_q, out_sel_d;
  logic                    eol_q, eol_d;
  logic                    eof_q, eof_d;

  logic                    restart;
  logic                    end_of_line;

  // A frame_start beat, or any beat while idle, is pixel (0,0) of a new frame.
  assign restart     = frame_start || (state_q == StIdle);
  assign end_of_line = (col_q == ColLast);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      line_q      <= '0;
      wr_sel_q    <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      line_q      <= line_d;
      wr_sel_q    <= wr_sel_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    wr_sel_d    = wr_sel_q;
    out_valid_d = 1'b0;
    out_sel_d   = out_sel_q;
    eol_d       = 1'b0;
    eof_d       = 1'b0;

    if (in_valid) begin
      if (restart) begin
        // This beat is written to RAM 0 column 0; counters point at column 1.
        // Restart overrides any end-of-line/frame update, so an aborted frame
        // produces no eol/eof.
        state_d  = StFill0;
        col_d    = ColOne;
        line_d   = '0;
        wr_sel_d = '0;
      end else begin
        if (state_q == StRun) begin
          out_valid_d = 1'b1;
          out_sel_d   = wr_sel_q;
        end

        if (end_of_line) begin
          col_d = '0;
          eol_d = 1'b1;
          if ((state_q == StRun) && (line_q == LineLast)) begin
            eof_d    = 1'b1;
            line_d   = '0;
            wr_sel_d = '0;
            state_d  = StIdle;
          end else begin
            line_d   = line_q + 8'd1;
            wr_sel_d = (wr_sel_q == 2'd2) ? 2'd0 : wr_sel_q + 2'd1;
            unique case (state_q)
              StFill0: state_d = StFill1;
              StFill1: state_d = StRun;
              default: state_d = state_q;
            endcase
          end
        end else begin
          col_d = col_q + ColOne;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // RAM control, combinational from registered state and the current beat
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en   = 3'b000;
    wr_addr = col_q;
    if (in_valid) begin
      if (frame_start) begin
        // The restarting beat always lands at RAM 0, column 0.
        wr_en   = 3'b001;
        wr_addr = '0;
      end else begin
        unique case (wr_sel_q)
          2'd0:    wr_en = 3'b001;
          2'd1:    wr_en = 3'b010;
          2'd2:    wr_en = 3'b100;
          default: wr_en = 3'b000;
        endcase
      end
    end
  end

  assign rd_addr   = wr_addr;
  assign rd_en     = in_valid && (state_q == StRun);

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign eol       = eol_q;
  assign eof       = eof_q;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Testbench for linebuf_ctrl with LENGTH=100, LINES=4. The reference model
// tracks only the pixel index within the current frame; column, line, RAM
// rotation and window availability are derived from it arithmetically.
module tb_linebuf_ctrl;

  localparam int AW  = 7;
  localparam int LEN = 100;
  localparam int LNS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          frame_start;
  logic [2:0]    wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    out_sel;
  logic          out_valid;
  logic          eol;
  logic          eof;

  linebuf_ctrl #(
    .ADDR_WIDTH (AW),
    .LENGTH     (LEN),
    .LINES      (LNS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .out_sel     (out_sel),
    .out_valid   (out_valid),
    .eol         (eol),
    .eof         (eof)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pixel index within the frame plus expected registered outputs.
  int n_pix = 0;
  int m_ov  = 0;
  int m_os  = 0;
  int m_eol = 0;
  int m_eof = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d (pixel %0d)", tag, got, exp, n_pix);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, update
  // the model, check registered outputs.
  task automatic step(input logic v, input logic fs, input logic rst);
    int ln;
    int cl;
    int e_we;
    int e_addr;
    int e_rd;
    in_valid    = v;
    frame_start = fs;
    rst_n       = !rst;
    #1;
    ln     = n_pix / LEN;
    cl     = n_pix % LEN;
    e_we   = !v ? 0 : (fs ? 1 : (1 << (ln % 3)));
    e_addr = (v && fs) ? 0 : cl;
    e_rd   = (v && ln >= 2) ? 1 : 0;
    check("wr_en",   32'(wr_en),   e_we);
    check("wr_addr", 32'(wr_addr), e_addr);
    check("rd_addr", 32'(rd_addr), e_addr);
    check("rd_en",   32'(rd_en),   e_rd);
    @(posedge clk);
    if (rst) begin
      n_pix = 0; m_ov = 0; m_os = 0; m_eol = 0; m_eof = 0;
    end else if (v && fs) begin
      n_pix = 1; m_ov = 0; m_eol = 0; m_eof = 0;
    end else if (v) begin
      m_ov  = (ln >= 2) ? 1 : 0;
      if (m_ov != 0) m_os = ln % 3;
      m_eol = (cl == LEN - 1) ? 1 : 0;
      m_eof = (n_pix == LEN * LNS - 1) ? 1 : 0;
      n_pix = (m_eof != 0) ? 0 : n_pix + 1;
    end else begin
      m_ov = 0; m_eol = 0; m_eof = 0;
    end
    #1;
    check("out_valid", 32'(out_valid), m_ov);
    check("eol",       32'(eol),       m_eol);
    check("eof",       32'(eof),       m_eof);
    if (m_ov != 0 || rst) check("out_sel", 32'(out_sel), m_os);
  endtask

  task automatic beats(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int cnt;
    int ln;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    rst_n       = 1'b0;

    // Reset state.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Continuous full frame, end-of-frame boundary, then idle gap.
    beats(LEN * LNS);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Next beat without frame_start starts a new frame at (0,0).
    beats(3);

    // Realign, then in_valid toggling every cycle through a full frame.
    step(1'b1, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 1; i < LEN * LNS; i++) begin
      ln = n_pix / LEN;
      step(1'b1, 1'b0, 1'b0);
      if (ln == 2 && out_valid) cnt++;
      step(1'b0, 1'b0, 1'b0);
    end
    check("toggle_line2_out_valid_count", cnt, 100);

    // frame_start aborting the frame at line 2, column 37.
    beats(2 * LEN + 37);
    check("abort_pos", n_pix, 2 * LEN + 37);
    step(1'b1, 1'b1, 1'b0);
    beats(LEN * LNS - 1);

    // Reset for one cycle at line 3, column 50.
    beats(3 * LEN + 50);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    beats(LEN + 5);

    // Random gaps, occasional frame_start and rare resets.
    for (int i = 0; i < 5000; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/linebuf_ctrl.md
LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, meaning the line RAM address width.
REQ-002 SHALL have parameter LENGTH, default 100, meaning pixels per line (2 <= LENGTH <= 2**ADDR_WIDTH).
REQ-003 SHALL have parameter LINES, default 64, meaning lines per frame (3 <= LINES <= 255).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning the reset; it is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning a pixel is presented this cycle ("accepted beat").
REQ-007 SHALL have port frame_start, input, 1 bit, meaning the accepted beat is pixel (0,0) of a new frame; it is ignored when in_valid=0.
REQ-008 SHALL have port wr_en, output, 3 bits, meaning a one-hot write strobe to line RAMs 0..2.
REQ-009 SHALL have port wr_addr, output, ADDR_WIDTH bits, meaning the write address (current column).
REQ-010 SHALL have port rd_en, output, 1 bit, meaning read all three RAMs at rd_addr.
REQ-011 SHALL have port rd_addr, output, ADDR_WIDTH bits, meaning the read address, equal to wr_addr.
REQ-012 SHALL have port out_sel, output, 2 bits, meaning the index of the newest line RAM, aligned with out_valid.
REQ-013 SHALL have port out_valid, output, 1 bit, meaning the three-line column output is valid.
REQ-014 SHALL have port eol, output, 1 bit, meaning a one-cycle pulse, registered, after the last column of a line.
REQ-015 SHALL have port eof, output, 1 bit, meaning a one-cycle pulse, registered, after the last pixel of a frame.

Function
REQ-016 SHALL hold registered col (0..LENGTH-1), line (0..LINES-1), wr_sel (0..2) and state in {IDLE, FILL0, FILL1, RUN}.
REQ-017 SHALL drive wr_en, wr_addr, rd_en and rd_addr combinationally from registered state and in_valid: wr_en = in_valid ? onehot(wr_sel) : 0, wr_addr = rd_addr = col, rd_en = in_valid && state==RUN.
REQ-018 SHALL, on each accepted beat, advance col by 1; at col==LENGTH-1 it SHALL wrap col to 0, increment line, advance wr_sel 0->1->2->0 and pulse eol on the next cycle.
REQ-019 SHALL hold all counters and the state on cycles with in_valid=0; gaps of any length SHALL be allowed.
REQ-020 SHALL use these state transitions: IDLE->FILL0 on an accepted beat; FILL0->FILL1 at end of line; FILL1->RUN at end of line; RUN->IDLE at end of line LINES-1.
REQ-021 SHALL, in the IDLE state, treat an accepted beat as pixel (0,0) of a new frame regardless of frame_start, with wr_sel=0.
REQ-022 SHALL, on frame_start && in_valid in any state, write that beat to RAM 0 at address 0, set col=1, line=0, wr_sel=0 and state=FILL0, and SHALL suppress out_valid for it; an aborted frame SHALL NOT pulse eol or eof.
REQ-023 SHALL assert out_valid one cycle after every accepted beat in RUN, with out_sel = wr_sel of that beat; RAM (out_sel+1)%3 holds the oldest line and (out_sel+2)%3 the middle line.
REQ-024 SHALL pulse eof together with eol on the cycle after pixel (LENGTH-1, LINES-1), then return to IDLE with col=0, line=0, wr_sel=0.
REQ-025 SHALL keep out_valid=0 in IDLE, FILL0 and FILL1; the first out_valid SHALL follow pixel (0,2).
REQ-026 SHALL give frame_start priority over the end-of-line and end-of-frame updates when they coincide on the same beat.

Reset
REQ-027 SHALL, on the rising clk edge with rst_n=0, set state=IDLE, col=0, line=0, wr_sel=0, out_valid=0, out_sel=0, eol=0, eof=0; wr_en=0 and rd_en=0 SHALL follow combinationally.
REQ-028 SHALL let reset asserted mid-frame discard the frame with no eol or eof pulse.

Verification
REQ-029 SHALL cover continuous in_valid with LENGTH=100, LINES=4 from reset: wr_en=001 for 100 beats, then 010, then 100, then 001; first out_valid after beat 200 with out_sel=2; eol every 100 beats; eof after beat 399; state back to IDLE.
REQ-030 SHALL cover in_valid toggling 1/0 every cycle: counters hold on the 0 cycles; exactly 100 out_valid pulses on line 2; eol after the 100th accepted beat of each line.
REQ-031 SHALL cover frame_start at line 2, col 37: wr_en=001 with wr_addr=0 for that beat; out_valid stays low for 200 more beats; no eol is emitted for the aborted line.
REQ-032 SHALL cover rst_n=0 for one cycle at line 3, col 50: next cycle all outputs are 0; the next beat goes to RAM 0 at address 0.
REQ-033 SHALL cover the end-of-frame boundary: the beat at (99,3) gives eol=eof=1 on the next cycle for exactly one cycle; the next beat without frame_start starts at (0,0) with wr_en=001.
